network_run_scheduler: RTL and testbench

Sequences the spiking network core between the packet source and the packet sink. It accepts run, clear and sync commands over a valid/ready handshake. It drives the network's enable, active-low reset and sync strobe, and stalls network timesteps whenever the downstream sink cannot accept output. It replaces the fixed "always enabled, always ready" arrangement with explicit, back-pressure-aware timestep control.

---
 rtl/network_run_scheduler_if.sv | 24 ++
 rtl/network_run_scheduler.sv | 68 ++++++
 tb/tb_network_run_scheduler.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/network_run_scheduler_if.sv
// network_run_scheduler_if: command handshake and network control bundle
interface network_run_scheduler_if #(
  parameter int RUN_WIDTH = 16,
  parameter int STEP_WIDTH = 32
);
  logic cmd_valid;
  logic cmd_ready;
  logic [1:0] cmd_op;
  logic [RUN_WIDTH-1:0] cmd_arg;
  logic out_ready;
  logic net_en;
  logic net_arstn;
  logic net_sync;
  logic busy;
  logic [STEP_WIDTH-1:0] step_count;
  modport master (
    output cmd_valid, cmd_op, cmd_arg, out_ready,
    input cmd_ready, net_en, net_arstn, net_sync, busy, step_count
  );
  modport slave (
    input cmd_valid, cmd_op, cmd_arg, out_ready,
    output cmd_ready, net_en, net_arstn, net_sync, busy, step_count
  );
endinterface

// File: rtl/network_run_scheduler.sv
// network_run_scheduler: back-pressure-aware timestep sequencer for the spiking network core
module network_run_scheduler #(
  parameter int RUN_WIDTH = 16,
  parameter int CLR_CYCLES = 2,
  parameter int STEP_WIDTH = 32
) (
  input logic clk,
  input logic arst,
  network_run_scheduler_if.slave bus
);
  localparam logic [1:0] st_idle = 2'd0, st_run = 2'd1, st_clr = 2'd2, st_sync = 2'd3;
  localparam logic [1:0] op_run = 2'd1, op_clr = 2'd2, op_sync = 2'd3;
  logic [1:0] state;
  logic [RUN_WIDTH-1:0] remaining;
  logic [7:0] clr_cnt;
  logic [STEP_WIDTH-1:0] step_count;
  logic net_arstn;
  logic accept;
  // IDLE reads as ready while reset is held; out_ready is the only combinational input to net_en
  always_comb begin
    bus.cmd_ready = state == st_idle && (net_arstn || arst);
    bus.net_en = state == st_run && bus.out_ready;
    bus.net_sync = state == st_sync;
    bus.busy = state != st_idle;
    bus.net_arstn = net_arstn;
    bus.step_count = step_count;
    accept = bus.cmd_valid && bus.cmd_ready;
  end
  // command sequencing, run countdown with stall, clear pulse and step counter
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      state <= st_idle;
      remaining <= '0;
      clr_cnt <= '0;
      step_count <= '0;
      net_arstn <= 1'b0;
    end else
      case (state)
        st_idle: begin
          net_arstn <= 1'b1;
          if (accept && bus.cmd_op == op_run && bus.cmd_arg != '0) begin
            remaining <= bus.cmd_arg;
            state <= st_run;
          end
          if (accept && bus.cmd_op == op_clr) begin
            clr_cnt <= 8'(CLR_CYCLES);
            net_arstn <= 1'b0;
            state <= st_clr;
          end
          if (accept && bus.cmd_op == op_sync) state <= st_sync;
        end
        st_run:
          if (bus.net_en) begin
            remaining <= remaining - 1'b1;
            step_count <= step_count + 1'b1;
            state <= remaining == RUN_WIDTH'(1) ? st_idle : st_run;
          end
        st_clr: begin
          clr_cnt <= clr_cnt - 8'd1;
          if (clr_cnt == 8'd1) begin
            net_arstn <= 1'b1;
            step_count <= '0;
            state <= st_idle;
          end
        end
        default: state <= st_idle;
      endcase
endmodule

// File: tb/tb_network_run_scheduler.sv
// tb_network_run_scheduler: randomized and directed checks against a count-based reference model
module tb_network_run_scheduler;
  localparam int RW = 16, SW = 32, CLR = 2;
  logic clk = 1'b0;
  logic arst = 1'b1;
  int errors = 0;
  int checks = 0;
  int m_steps, m_clr;
  bit m_sync, m_up;
  logic [SW-1:0] m_count;
  network_run_scheduler_if #(.RUN_WIDTH(RW), .STEP_WIDTH(SW)) bus ();
  network_run_scheduler #(.RUN_WIDTH(RW), .CLR_CYCLES(CLR), .STEP_WIDTH(SW)) dut (
    .clk(clk),
    .arst(arst),
    .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Reference: outstanding timesteps, clear cycles left, pending sync pulse, network-out-of-reset flag
  always @(posedge clk or posedge arst)
    if (arst) begin
      m_steps = 0; m_clr = 0; m_sync = 0; m_up = 0; m_count = '0;
    end else begin
      bit idle, acc;
      idle = m_steps == 0 && m_clr == 0 && !m_sync;
      acc = idle && m_up && bus.cmd_valid;
      if (m_clr > 0) begin
        m_clr--;
        if (m_clr == 0) m_count = '0;
      end else if (m_steps > 0) begin
        if (bus.out_ready) begin m_steps--; m_count++; end
      end else if (m_sync) m_sync = 0;
      else begin
        m_up = 1;
        if (acc && bus.cmd_op == 2'd1) m_steps = int'(bus.cmd_arg);
        if (acc && bus.cmd_op == 2'd2) m_clr = CLR;
        if (acc && bus.cmd_op == 2'd3) m_sync = 1;
      end
    end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    bit b;
    #2;
    b = m_steps > 0 || m_clr > 0 || m_sync;
    chk("cmd_ready", 64'(bus.cmd_ready), 64'(!b && (m_up || arst)));
    chk("net_en", 64'(bus.net_en), 64'(m_steps > 0 && bus.out_ready));
    chk("net_arstn", 64'(bus.net_arstn), 64'(m_up && m_clr == 0));
    chk("net_sync", 64'(bus.net_sync), 64'(m_sync));
    chk("busy", 64'(bus.busy), 64'(b));
    chk("step_count", 64'(bus.step_count), 64'(m_count));
  end

  task automatic send(input logic [1:0] op, input logic [RW-1:0] arg);
    int n = 0;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_arg = arg;
    #1;
    while (!bus.cmd_ready && n < 300) begin
      @(negedge clk); #1; n++;
    end
    if (n == 300) timeout("send");
    @(negedge clk);
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'($urandom); bus.cmd_arg = RW'($urandom);
  endtask

  initial begin
    logic [7:0] en_t, sy_t, bz_t, rs_t;
    logic [7:0] pat;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_arg = '0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_net_arstn", 64'(bus.net_arstn), 64'd0);
    chk("rst_net_en", 64'(bus.net_en), 64'd0);
    @(negedge clk);
    arst = 1'b0;
    #1;
    chk("rel_net_arstn_low", 64'(bus.net_arstn), 64'd0);
    @(negedge clk); #1;
    chk("rel_net_arstn_high", 64'(bus.net_arstn), 64'd1);
    chk("rel_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rel_step_count", 64'(bus.step_count), 64'd0);
    send(2'd1, 16'd5);
    for (int i = 0; i < 7; i++) begin
      #1; en_t[i] = bus.net_en; bz_t[i] = bus.busy; @(negedge clk);
    end
    chk("run5_en", 64'(en_t[6:0]), 64'b0011111);
    chk("run5_busy", 64'(bz_t[6:0]), 64'b0011111);
    #1;
    chk("run5_count", 64'(bus.step_count), 64'd5);
    chk("run5_ready", 64'(bus.cmd_ready), 64'd1);
    send(2'd1, 16'd4);
    pat = 8'b11011001;
    for (int i = 0; i < 8; i++) begin
      bus.out_ready = pat[i]; #1; en_t[i] = bus.net_en; bz_t[i] = bus.busy; @(negedge clk);
    end
    bus.out_ready = 1'b1;
    chk("run4_en", 64'(en_t), 64'b01011001);
    chk("run4_busy", 64'(bz_t), 64'b01111111);
    #1;
    chk("run4_count", 64'(bus.step_count), 64'd9);
    send(2'd1, 16'd0);
    send(2'd0, 16'd7);
    for (int i = 0; i < 3; i++) begin
      #1; bz_t[i] = bus.busy | bus.net_en | !bus.cmd_ready; @(negedge clk);
    end
    chk("nop_idle", 64'(bz_t[2:0]), 64'd0);
    send(2'd2, 16'd3);
    for (int i = 0; i < 4; i++) begin
      #1; rs_t[i] = bus.net_arstn; en_t[i] = bus.net_en; @(negedge clk);
    end
    chk("clr_arstn", 64'(rs_t[3:0]), 64'b1100);
    chk("clr_en", 64'(en_t[3:0]), 64'd0);
    #1;
    chk("clr_count", 64'(bus.step_count), 64'd0);
    send(2'd1, 16'd3);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd3;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) bus.cmd_valid = 1'b0;
      #1; en_t[i] = bus.net_en; sy_t[i] = bus.net_sync; @(negedge clk);
    end
    chk("sync_en", 64'(en_t[5:0]), 64'b000111);
    chk("sync_pulse", 64'(sy_t[5:0]), 64'b010000);
    send(2'd1, 16'd100);
    repeat (10) @(negedge clk);
    #3;
    arst = 1'b1;
    #1;
    chk("abort_en", 64'(bus.net_en), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_count", 64'(bus.step_count), 64'd0);
    chk("abort_ready", 64'(bus.cmd_ready), 64'd1);
    @(negedge clk);
    arst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      arst = $urandom_range(0, 299) == 0;
      bus.out_ready = $urandom_range(0, 3) != 0;
      bus.cmd_valid = $urandom_range(0, 2) == 0;
      bus.cmd_op = 2'($urandom);
      bus.cmd_arg = $urandom_range(0, 7) == 0 ? RW'($urandom) % 16'd40 : RW'($urandom_range(0, 6));
    end
    @(negedge clk);
    arst = 1'b0;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
